gate_exerciser: RTL and testbench

//  Driver/checker for a combinational gate under test (DUT): drives every input vector

---
 rtl/gate_exerciser.sv | 112 +++++++++++
 tb/tb_gate_exerciser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// Sweeps every input vector of a combinational gate, samples its output after a settle
// period and counts mismatches against the selected reference function.
module gate_exerciser #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int FUNC          = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   fail_count,
  output logic [N_INPUTS-1:0] first_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = '1;
  localparam logic [N_INPUTS-1:0] VEC_ONE  = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]   FC_ONE   = (N_INPUTS + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  // Unsupported FUNC codes fall back to AND-reduce.
  function automatic logic expected_out(input logic [N_INPUTS-1:0] v);
    case (FUNC)
      1:       expected_out = |v;
      2:       expected_out = ^v;
      3:       expected_out = ~&v;
      4:       expected_out = ~|v;
      default: expected_out = &v;
    endcase
  endfunction

  assign mismatch = (dut_out != expected_out(vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_DRIVE;
      ST_DRIVE:  if (cnt == CNT_LAST) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (vec == VEC_LAST) ? ST_FINISH : ST_DRIVE;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so the FINISH actions become visible one cycle after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec            <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
          end
        end
        ST_DRIVE: cnt <= cnt + CNT_ONE;
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_count <= fail_count + FC_ONE;
            if (fail_count == '0) first_fail_vec <= vec;
          end
          if (vec != VEC_LAST) begin
            vec <= vec + VEC_ONE;
            cnt <= '0;
          end
        end
        ST_FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (fail_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two configurations, sweep results checked by a done-driven
// scoreboard monitor, with directed vector/reset checks from the stimulus thread.
module tb_gate_exerciser;

  typedef struct {
    logic pass;
    int   fc;
    int   ff;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       start_a = 1'b0;
  logic       dut_out_a;
  logic [1:0] vec_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] fc_a;
  logic [1:0] ff_a;
  int         mode_a = 0;

  logic       start_b = 1'b0;
  logic       dut_out_b;
  logic [2:0] vec_b;
  logic       busy_b, done_b, pass_b;
  logic [3:0] fc_b;
  logic [2:0] ff_b;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: good AND gate, 1: stuck-at-0, 2: stuck-at-1
  assign dut_out_a = (mode_a == 0) ? &vec_a : (mode_a == 1) ? 1'b0 : 1'b1;
  assign dut_out_b = ^vec_b;

  gate_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(1), .FUNC(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a), .vec(vec_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .first_fail_vec(ff_a)
  );

  gate_exerciser #(.N_INPUTS(3), .SETTLE_CYCLES(3), .FUNC(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b), .vec(vec_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .first_fail_vec(ff_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_pass", int'(pass_a), int'(e.pass));
        chk("a_fail_count", int'(fc_a), e.fc);
        chk("a_first_fail_vec", int'(ff_a), e.ff);
        chk("a_busy_at_done", int'(busy_a), 0);
        chk("a_done_edge", cyc, e.done_cyc);
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_pass", int'(pass_b), int'(e.pass));
        chk("b_fail_count", int'(fc_b), e.fc);
        chk("b_first_fail_vec", int'(ff_b), e.ff);
        chk("b_busy_at_done", int'(busy_b), 0);
        chk("b_done_edge", cyc, e.done_cyc);
      end
    end
  end

  task automatic wait_drain_a();
    for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
  endtask

  task automatic wait_drain_b();
    for (int i = 0; i < 400 && q_b.size() != 0; i++) @(negedge clk);
    chk("b_queue_drained", q_b.size(), 0);
  endtask

  // Pulse start on instance A at a negedge; accept edge is the following posedge.
  task automatic run_a(input logic p, input int fc, input int ff, input bit chk_vec);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1;
    e.pass = p; e.fc = fc; e.ff = ff; e.done_cyc = cyc + 1 + 9;
    q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", int'(busy_a), 1);
    chk("a_pass_cleared", int'(pass_a), 0);
    if (chk_vec) begin
      for (int i = 0; i < 8; i++) begin
        chk("a_vec_seq", int'(vec_a), i / 2);
        @(negedge clk);
      end
      chk("a_vec_held_last", int'(vec_a), 3);
    end
    wait_drain_a();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_vec"}, int'(vec_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_fc"}, int'(fc_a), 0);
    chk({tag, "_ff"}, int'(ff_a), 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    chk_reset_a("a_rst");
    chk("b_rst_vec", int'(vec_b), 0);
    chk("b_rst_busy", int'(busy_b), 0);
    chk("b_rst_pass", int'(pass_b), 0);
    rst_n = 1'b1;

    // good AND gate, full vector sequence
    mode_a = 0;
    run_a(1'b1, 0, 0, 1'b1);
    // stuck-at-0: only vector 3 expects 1
    mode_a = 1;
    run_a(1'b0, 1, 3, 1'b1);
    // stuck-at-1: vectors 0,1,2 mismatch
    mode_a = 2;
    run_a(1'b0, 3, 0, 1'b0);

    // start pulses mid-sweep and during the final state must be ignored
    mode_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    e.pass = 1'b1; e.fc = 0; e.ff = 0; e.done_cyc = cyc + 1 + 9;
    q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    wait_drain_a();
    chk("a_no_restart_busy", int'(busy_a), 0);
    chk("a_held_pass", int'(pass_a), 1);
    chk("a_held_fc", int'(fc_a), 0);

    // asynchronous reset while vec==2, then a clean sweep
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("a_vec_before_reset", int'(vec_a), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_a("a_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_a(1'b1, 0, 0, 1'b1);

    // 3-input XOR, settle 3: each vector held 4 cycles, done after edge 33
    @(negedge clk);
    start_b = 1'b1;
    e.pass = 1'b1; e.fc = 0; e.ff = 0; e.done_cyc = cyc + 1 + 33;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("b_vec_seq", int'(vec_b), i / 4);
      @(negedge clk);
    end
    wait_drain_b();

    repeat (5) @(negedge clk);
    chk("a_final_queue", q_a.size(), 0);
    chk("b_final_queue", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
